ecc_sed_decoder: RTL and testbench

Receive-side counterpart of the single-error-detect (SED) parity encoder. Accepts 13-bit codewords (data[11:0] plus even-parity bit at [12]) and checks parity. Forwards the data word with a per-word error flag through a 2-entry elastic buffer under valid/ready handshake. Keeps a saturating error counter and a sticky error flag for status logic. Detects single-bit (any odd-weight) errors; no correction.

---
 rtl/ecc_sed_decoder.sv | 107 ++++++++++
 tb/tb_ecc_sed_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ecc_sed_decoder.sv
// Single-error-detect parity checker feeding a 2-entry elastic buffer.
// Tracks a saturating error count and a sticky error flag at push time.
module ecc_sed_decoder #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W:0]   enc_codeword,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky,
    input  logic              clr_err
);

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic [1:0]        err_q;
    logic [1:0]        err_d;
    logic [1:0]        occ_q, occ_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;

    logic syndrome;
    logic push;
    logic pop;

    // Even parity over the full codeword: any odd number of flips is flagged.
    assign syndrome  = ^enc_codeword;
    assign enc_ready = (occ_q != 2'd2);
    assign dec_valid = (occ_q != 2'd0);
    assign push      = enc_valid && enc_ready;
    assign pop       = dec_valid && dec_ready;

    assign dec_data   = data_q[rd_ptr_q];
    assign dec_err    = err_q[rd_ptr_q];
    assign err_count  = cnt_q;
    assign err_sticky = sticky_q;

    always_comb begin
        data_d   = data_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            data_d[wr_ptr_q] = enc_codeword[DATA_W-1:0];
            err_d[wr_ptr_q]  = syndrome;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_err) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
        if (push && syndrome) begin
            sticky_d = 1'b1;
            // A clear in the same cycle still counts the incoming error.
            if (clr_err) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            err_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
        end else begin
            data_q    <= data_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
        end
    end

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Directed-vector bench for ecc_sed_decoder; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_ecc_sed_decoder;

    logic        clk;
    logic        rst;
    logic        enc_valid;
    logic [12:0] enc_codeword;
    logic        dec_ready;
    logic        clr_err;

    logic        enc_ready, dec_valid, dec_err, err_sticky;
    logic [11:0] dec_data;
    logic [7:0]  err_count;

    logic        s_enc_ready, s_dec_valid, s_dec_err, s_err_sticky;
    logic [11:0] s_dec_data;
    logic [1:0]  s_err_count;

    int n_vec;
    int n_err;

    ecc_sed_decoder #(.DATA_W(12), .CNT_W(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enc_valid    (enc_valid),
        .enc_ready    (enc_ready),
        .enc_codeword (enc_codeword),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_data     (dec_data),
        .dec_err      (dec_err),
        .err_count    (err_count),
        .err_sticky   (err_sticky),
        .clr_err      (clr_err)
    );

    ecc_sed_decoder #(.DATA_W(12), .CNT_W(2)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .enc_valid    (enc_valid),
        .enc_ready    (s_enc_ready),
        .enc_codeword (enc_codeword),
        .dec_valid    (s_dec_valid),
        .dec_ready    (dec_ready),
        .dec_data     (s_dec_data),
        .dec_err      (s_dec_err),
        .err_count    (s_err_count),
        .err_sticky   (s_err_sticky),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a codeword for one edge, then sample 1 time unit later.
    task automatic push_word(input logic [12:0] cw);
        enc_valid    = 1'b1;
        enc_codeword = cw;
        @(posedge clk);
        #1;
        enc_valid    = 1'b0;
        enc_codeword = 'x;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b0;
        enc_valid    = 1'b0;
        enc_codeword = '0;
        dec_ready    = 1'b1;
        clr_err      = 1'b0;

        idle_cycle();
        check("rst_dec_valid", dec_valid, 0);
        check("rst_dec_data", dec_data, 0);
        check("rst_dec_err", dec_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_enc_ready", enc_ready, 1);
        rst = 1'b1;

        // Good word
        push_word(13'h0A5F);
        check("good_valid", dec_valid, 1);
        check("good_data", dec_data, 12'hA5F);
        check("good_err", dec_err, 0);
        check("good_count", err_count, 0);

        // Data-bit error, then a good word with parity bit set
        push_word(13'h0A5E);
        check("derr_data", dec_data, 12'hA5E);
        check("derr_err", dec_err, 1);
        check("derr_count", err_count, 1);
        check("derr_sticky", err_sticky, 1);
        push_word(13'h1001);
        check("good2_data", dec_data, 12'h001);
        check("good2_err", dec_err, 0);
        check("good2_count", err_count, 1);

        // Parity-bit error and undetectable double error
        push_word(13'h1A5F);
        check("perr_data", dec_data, 12'hA5F);
        check("perr_err", dec_err, 1);
        check("perr_count", err_count, 2);
        push_word(13'h0A5C);
        check("dbl_data", dec_data, 12'hA5C);
        check("dbl_err", dec_err, 0);
        check("dbl_count", err_count, 2);
        idle_cycle();
        check("drain_valid", dec_valid, 0);

        // Backpressure
        dec_ready = 1'b0;
        push_word(13'h1001);
        check("bp_a_ready", enc_ready, 1);
        check("bp_a_data", dec_data, 12'h001);
        push_word(13'h1002);
        check("bp_full_ready", enc_ready, 0);
        check("bp_head_data", dec_data, 12'h001);
        push_word(13'h0003);
        check("bp_hold_data", dec_data, 12'h001);
        check("bp_hold_ready", enc_ready, 0);
        check("bp_hold_valid", dec_valid, 1);
        dec_ready = 1'b1;
        idle_cycle();
        check("bp_b_data", dec_data, 12'h002);
        check("bp_b_valid", dec_valid, 1);
        check("bp_b_ready", enc_ready, 1);
        idle_cycle();
        check("bp_empty_valid", dec_valid, 0);
        check("bp_count", err_count, 2);

        // Saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            push_word(13'h0001);
        end
        check("sat_count_w2", s_err_count, 3);
        check("sat_count_w8", err_count, 7);
        check("sat_err_flag", dec_err, 1);
        clr_err = 1'b1;
        push_word(13'h0001);
        check("clr_push_count", s_err_count, 1);
        check("clr_push_sticky", s_err_sticky, 1);
        check("clr_push_count_w8", err_count, 1);
        idle_cycle();
        clr_err = 1'b0;
        check("clr_only_count", s_err_count, 0);
        check("clr_only_sticky", s_err_sticky, 0);
        check("clr_only_count_w8", err_count, 0);
        check("clr_only_sticky_w8", err_sticky, 0);

        // Reset mid-operation with a full buffer
        dec_ready = 1'b0;
        push_word(13'h0001);
        push_word(13'h0002);
        check("pre_rst_count", err_count, 2);
        check("pre_rst_ready", enc_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", dec_valid, 0);
        check("async_rst_count", err_count, 0);
        check("async_rst_sticky", err_sticky, 0);
        check("async_rst_ready", enc_ready, 1);
        idle_cycle();
        rst       = 1'b1;
        dec_ready = 1'b1;
        push_word(13'h0A5F);
        check("post_rst_valid", dec_valid, 1);
        check("post_rst_data", dec_data, 12'hA5F);
        check("post_rst_err", dec_err, 0);
        idle_cycle();
        check("post_rst_drain", dec_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
